// File: rtl/mem_arbiter.sv
// Purpose : arbitrates one shared single-port memory between instruction fetch (IF) and data memory (DM).
// Latency : ack pulses MEM_LAT+2 cycles after the IDLE cycle in which the request was sampled.
// Backpressure: the loser and any in-flight requester see stall_*; requests are only sampled in IDLE.
//
// Ports:
//   clk_i, rst_i                          clock, synchronous active-high reset
//   if_req_i/if_addr_i -> if_ack_o/if_rdata_o          fetch read channel
//   dm_req_i/dm_we_i/dm_addr_i/dm_wdata_i -> dm_ack_o/dm_rdata_o   load/store channel
//   mem_en_o/mem_we_o/mem_addr_o/mem_wdata_o, mem_rdata_i          shared memory port
//   stall_if_o, stall_dm_o                pipeline freeze requests (combinational)
module mem_arbiter #(
    parameter int MEM_LAT = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic        if_ack_o,
    output logic [31:0] if_rdata_o,
    input  logic        dm_req_i,
    input  logic        dm_we_i,
    input  logic [31:0] dm_addr_i,
    input  logic [31:0] dm_wdata_i,
    output logic        dm_ack_o,
    output logic [31:0] dm_rdata_o,
    output logic        mem_en_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    output logic        stall_if_o,
    output logic        stall_dm_o
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    localparam logic       GRANT_IF = 1'b0;
    localparam logic       GRANT_DM = 1'b1;
    // ISSUE loads MEM_LAT-1 so the capture edge lands MEM_LAT cycles after the issue cycle.
    localparam logic [3:0] LAT_LOAD = 4'(MEM_LAT - 1);

    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic        last_grant, last_grant_nxt;
    logic        winner, winner_nxt;
    logic        grant_dm;

    logic        mem_en_nxt, mem_we_nxt;
    logic [31:0] mem_addr_nxt, mem_wdata_nxt;
    logic        if_ack_nxt, dm_ack_nxt;
    logic [31:0] if_rdata_nxt, dm_rdata_nxt;

    // DM wins when alone, or on contention when IF had the previous grant.
    assign grant_dm   = dm_req_i && (!if_req_i || (last_grant == GRANT_IF));

    assign stall_if_o = if_req_i && !if_ack_o;
    assign stall_dm_o = dm_req_i && !dm_ack_o;

    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        last_grant_nxt = last_grant;
        winner_nxt     = winner;
        mem_en_nxt     = 1'b0;
        mem_we_nxt     = mem_we_o;
        mem_addr_nxt   = mem_addr_o;
        mem_wdata_nxt  = mem_wdata_o;
        if_ack_nxt     = 1'b0;
        dm_ack_nxt     = 1'b0;
        if_rdata_nxt   = if_rdata_o;
        dm_rdata_nxt   = dm_rdata_o;

        case (state)
            IDLE: begin
                if (if_req_i || dm_req_i) begin
                    state_nxt      = ISSUE;
                    mem_en_nxt     = 1'b1;
                    winner_nxt     = grant_dm;
                    last_grant_nxt = grant_dm;
                    if (grant_dm) begin
                        mem_we_nxt    = dm_we_i;
                        mem_addr_nxt  = dm_addr_i;
                        mem_wdata_nxt = dm_wdata_i;
                    end else begin
                        mem_we_nxt    = 1'b0;
                        mem_addr_nxt  = if_addr_i;
                        mem_wdata_nxt = '0;
                    end
                end
            end
            ISSUE: begin
                cnt_nxt   = LAT_LOAD;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (cnt == 4'd0) begin
                    state_nxt = DONE;
                    if (winner == GRANT_DM) begin
                        dm_ack_nxt = 1'b1;
                        // Stores complete with an ack but leave the load data untouched.
                        if (!mem_we_o) begin
                            dm_rdata_nxt = mem_rdata_i;
                        end
                    end else begin
                        if_ack_nxt   = 1'b1;
                        if_rdata_nxt = mem_rdata_i;
                    end
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            cnt         <= '0;
            last_grant  <= GRANT_IF;
            winner      <= GRANT_IF;
            mem_en_o    <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            if_ack_o    <= 1'b0;
            dm_ack_o    <= 1'b0;
            if_rdata_o  <= '0;
            dm_rdata_o  <= '0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            last_grant  <= last_grant_nxt;
            winner      <= winner_nxt;
            mem_en_o    <= mem_en_nxt;
            mem_we_o    <= mem_we_nxt;
            mem_addr_o  <= mem_addr_nxt;
            mem_wdata_o <= mem_wdata_nxt;
            if_ack_o    <= if_ack_nxt;
            dm_ack_o    <= dm_ack_nxt;
            if_rdata_o  <= if_rdata_nxt;
            dm_rdata_o  <= dm_rdata_nxt;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
module tb_mem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic        rst;
    logic        if_req, dm_req, dm_we;
    logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
    logic        if_ack, dm_ack, mem_en, mem_we, stall_if, stall_dm;
    logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;

    // Second and third instances exercise the latency extremes with an IF read only.
    logic        if_req1, if_req15;
    logic [31:0] const_rdata;
    logic        if_ack1, dm_ack1, mem_en1, mem_we1, stall_if1, stall_dm1;
    logic [31:0] if_rdata1, dm_rdata1, mem_addr1, mem_wdata1;
    logic        if_ack15, dm_ack15, mem_en15, mem_we15, stall_if15, stall_dm15;
    logic [31:0] if_rdata15, dm_rdata15, mem_addr15, mem_wdata15;

    mem_arbiter #(.MEM_LAT(2)) dut (
        .clk_i(clk), .rst_i(rst),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_ack_o(if_ack), .if_rdata_o(if_rdata),
        .dm_req_i(dm_req), .dm_we_i(dm_we), .dm_addr_i(dm_addr), .dm_wdata_i(dm_wdata),
        .dm_ack_o(dm_ack), .dm_rdata_o(dm_rdata),
        .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
        .mem_rdata_i(mem_rdata), .stall_if_o(stall_if), .stall_dm_o(stall_dm)
    );

    mem_arbiter #(.MEM_LAT(1)) u_lat1 (
        .clk_i(clk), .rst_i(rst),
        .if_req_i(if_req1), .if_addr_i(32'h30), .if_ack_o(if_ack1), .if_rdata_o(if_rdata1),
        .dm_req_i(1'b0), .dm_we_i(1'b0), .dm_addr_i(32'h0), .dm_wdata_i(32'h0),
        .dm_ack_o(dm_ack1), .dm_rdata_o(dm_rdata1),
        .mem_en_o(mem_en1), .mem_we_o(mem_we1), .mem_addr_o(mem_addr1), .mem_wdata_o(mem_wdata1),
        .mem_rdata_i(const_rdata), .stall_if_o(stall_if1), .stall_dm_o(stall_dm1)
    );

    mem_arbiter #(.MEM_LAT(15)) u_lat15 (
        .clk_i(clk), .rst_i(rst),
        .if_req_i(if_req15), .if_addr_i(32'h30), .if_ack_o(if_ack15), .if_rdata_o(if_rdata15),
        .dm_req_i(1'b0), .dm_we_i(1'b0), .dm_addr_i(32'h0), .dm_wdata_i(32'h0),
        .dm_ack_o(dm_ack15), .dm_rdata_o(dm_rdata15),
        .mem_en_o(mem_en15), .mem_we_o(mem_we15), .mem_addr_o(mem_addr15), .mem_wdata_o(mem_wdata15),
        .mem_rdata_i(const_rdata), .stall_if_o(stall_if15), .stall_dm_o(stall_dm15)
    );

    // Memory model for the MEM_LAT=2 instance: data is valid only in the cycle
    // two cycles after the issue cycle; otherwise a poison pattern is driven.
    function automatic logic [31:0] rd_val(input logic [31:0] a);
        if (a == 32'h10) return 32'h8C010004;
        return a ^ 32'hA5A50000;
    endfunction

    logic [3:0]  cd = 4'd0;
    logic [31:0] md = 32'h0;
    always @(posedge clk) begin
        if (mem_en) begin
            cd <= 4'd2;
            md <= rd_val(mem_addr);
        end else if (cd != 4'd0) begin
            cd <= cd - 4'd1;
        end
    end
    assign mem_rdata = (cd == 4'd1) ? md : 32'hBAD0BAD0;

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        next_cycle;
        next_cycle;
        @(negedge clk);
        checks++;
        if ({mem_en, mem_we, if_ack, dm_ack, stall_if, stall_dm} !== 6'b0) begin
            failures++;
            $display("FAIL reset_ctrl got=%b exp=000000", {mem_en, mem_we, if_ack, dm_ack, stall_if, stall_dm});
        end
        checks++;
        if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_mem addr=%h wdata=%h exp=0", mem_addr, mem_wdata);
        end
        checks++;
        if (if_rdata !== 32'h0 || dm_rdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_rdata if=%h dm=%h exp=0", if_rdata, dm_rdata);
        end
        rst = 1'b0;
        next_cycle;
    endtask

    task automatic test_if_read;
        if_addr = 32'h10;
        for (int k = 0; k < 7; k++) begin
            if_req = (k <= 4);
            @(negedge clk);
            checks++;
            if (mem_en !== (k == 1)) begin
                failures++;
                $display("FAIL if_read_en k=%0d got=%b exp=%b", k, mem_en, (k == 1));
            end
            checks++;
            if (if_ack !== (k == 4) || dm_ack !== 1'b0) begin
                failures++;
                $display("FAIL if_read_ack k=%0d if=%b dm=%b exp_if=%b", k, if_ack, dm_ack, (k == 4));
            end
            checks++;
            if (stall_if !== (k < 4)) begin
                failures++;
                $display("FAIL if_read_stall k=%0d got=%b exp=%b", k, stall_if, (k < 4));
            end
            if (k >= 1 && k <= 4) begin
                checks++;
                if (mem_addr !== 32'h10 || mem_we !== 1'b0) begin
                    failures++;
                    $display("FAIL if_read_cmd k=%0d addr=%h we=%b exp addr=00000010 we=0", k, mem_addr, mem_we);
                end
            end
            if (k == 4) begin
                checks++;
                if (if_rdata !== 32'h8C010004) begin
                    failures++;
                    $display("FAIL if_read_data got=%h exp=8c010004", if_rdata);
                end
            end
            next_cycle;
        end
    endtask

    task automatic test_contention;
        rst = 1'b1;
        next_cycle;
        rst = 1'b0;
        if_addr = 32'h14;
        dm_addr = 32'h40;
        dm_we   = 1'b0;
        for (int k = 0; k < 11; k++) begin
            if_req = (k <= 9);
            dm_req = (k <= 4);
            @(negedge clk);
            checks++;
            if (dm_ack !== (k == 4) || if_ack !== (k == 9)) begin
                failures++;
                $display("FAIL contention_ack k=%0d dm=%b if=%b exp dm=%b if=%b", k, dm_ack, if_ack, (k == 4), (k == 9));
            end
            checks++;
            if (stall_if !== (k <= 8) || stall_dm !== (k <= 3)) begin
                failures++;
                $display("FAIL contention_stall k=%0d if=%b dm=%b exp if=%b dm=%b", k, stall_if, stall_dm, (k <= 8), (k <= 3));
            end
            checks++;
            if (mem_en !== (k == 1 || k == 6)) begin
                failures++;
                $display("FAIL contention_en k=%0d got=%b exp=%b", k, mem_en, (k == 1 || k == 6));
            end
            if (k == 1 || k == 6) begin
                checks++;
                if (mem_addr !== ((k == 1) ? 32'h40 : 32'h14)) begin
                    failures++;
                    $display("FAIL contention_addr k=%0d got=%h", k, mem_addr);
                end
            end
            if (k == 4) begin
                checks++;
                if (dm_rdata !== 32'hA5A50040) begin
                    failures++;
                    $display("FAIL contention_dm_data got=%h exp=a5a50040", dm_rdata);
                end
            end
            if (k == 9) begin
                checks++;
                if (if_rdata !== 32'hA5A50014) begin
                    failures++;
                    $display("FAIL contention_if_data got=%h exp=a5a50014", if_rdata);
                end
            end
            next_cycle;
        end
    endtask

    task automatic test_round_robin;
        logic [5:0] order;
        int         n;
        order  = '0;
        n      = 0;
        if_req = 1'b1;
        dm_req = 1'b1;
        dm_we  = 1'b0;
        for (int c = 0; c < 60 && n < 6; c++) begin
            @(negedge clk);
            checks++;
            if (if_ack && dm_ack) begin
                failures++;
                $display("FAIL rr_both_ack cycle=%0d got=11 exp=not both", c);
            end
            if (if_ack || dm_ack) begin
                order[n] = dm_ack;
                n++;
            end
            next_cycle;
        end
        if_req = 1'b0;
        dm_req = 1'b0;
        checks++;
        if (n != 6 || order !== 6'b010101) begin
            failures++;
            $display("FAIL rr_order grants=%0d order=%b exp grants=6 order=010101 (bit0 first, 1=DM)", n, order);
        end
    endtask

    task automatic test_dm_write;
        dm_addr  = 32'h20;
        dm_we    = 1'b1;
        dm_wdata = 32'hDEADBEEF;
        for (int k = 0; k < 7; k++) begin
            dm_req = (k <= 4);
            @(negedge clk);
            checks++;
            if (mem_en !== (k == 1)) begin
                failures++;
                $display("FAIL wr_en k=%0d got=%b exp=%b", k, mem_en, (k == 1));
            end
            checks++;
            if (dm_ack !== (k == 4) || if_ack !== 1'b0) begin
                failures++;
                $display("FAIL wr_ack k=%0d dm=%b if=%b exp dm=%b", k, dm_ack, if_ack, (k == 4));
            end
            checks++;
            if (dm_rdata !== 32'hA5A50040) begin
                failures++;
                $display("FAIL wr_rdata_kept k=%0d got=%h exp=a5a50040", k, dm_rdata);
            end
            if (k >= 1 && k <= 4) begin
                checks++;
                if (mem_we !== 1'b1 || mem_addr !== 32'h20 || mem_wdata !== 32'hDEADBEEF) begin
                    failures++;
                    $display("FAIL wr_cmd k=%0d we=%b addr=%h wdata=%h exp 1/00000020/deadbeef", k, mem_we, mem_addr, mem_wdata);
                end
            end
            next_cycle;
        end
        dm_we = 1'b0;
    endtask

    task automatic test_reset_mid;
        if_addr = 32'h18;
        for (int k = 0; k < 9; k++) begin
            if_req = (k <= 1);
            rst    = (k == 2);
            @(negedge clk);
            if (k == 1) begin
                checks++;
                if (mem_en !== 1'b1) begin
                    failures++;
                    $display("FAIL rstmid_issue got=%b exp=1", mem_en);
                end
            end
            if (k == 3) begin
                checks++;
                if ({mem_en, mem_we, if_ack, dm_ack, stall_if, stall_dm} !== 6'b0 ||
                    mem_addr !== 32'h0 || mem_wdata !== 32'h0 || if_rdata !== 32'h0 || dm_rdata !== 32'h0) begin
                    failures++;
                    $display("FAIL rstmid_zero ctrl=%b addr=%h wdata=%h if_rd=%h dm_rd=%h exp all 0",
                             {mem_en, mem_we, if_ack, dm_ack, stall_if, stall_dm}, mem_addr, mem_wdata, if_rdata, dm_rdata);
                end
            end
            if (k >= 3) begin
                checks++;
                if (if_ack !== 1'b0 || mem_en !== 1'b0) begin
                    failures++;
                    $display("FAIL rstmid_no_ack k=%0d ack=%b en=%b exp 0/0", k, if_ack, mem_en);
                end
            end
            next_cycle;
        end
        rst = 1'b0;
        // Fresh read afterwards; req is dropped early and the ack must still come.
        if_addr = 32'h24;
        for (int k = 0; k < 6; k++) begin
            if_req = (k == 0);
            @(negedge clk);
            checks++;
            if (if_ack !== (k == 4)) begin
                failures++;
                $display("FAIL rstmid_next_ack k=%0d got=%b exp=%b", k, if_ack, (k == 4));
            end
            if (k == 4) begin
                checks++;
                if (if_rdata !== 32'hA5A50024) begin
                    failures++;
                    $display("FAIL rstmid_next_data got=%h exp=a5a50024", if_rdata);
                end
            end
            next_cycle;
        end
    endtask

    task automatic test_latency;
        for (int k = 0; k < 20; k++) begin
            if_req1  = (k <= 3);
            if_req15 = (k <= 17);
            @(negedge clk);
            checks++;
            if (if_ack1 !== (k == 3)) begin
                failures++;
                $display("FAIL lat1_ack k=%0d got=%b exp=%b", k, if_ack1, (k == 3));
            end
            checks++;
            if (if_ack15 !== (k == 17) || mem_en15 !== (k == 1)) begin
                failures++;
                $display("FAIL lat15 k=%0d ack=%b en=%b exp ack=%b en=%b", k, if_ack15, mem_en15, (k == 17), (k == 1));
            end
            if (k == 3) begin
                checks++;
                if (if_rdata1 !== 32'h12345678) begin
                    failures++;
                    $display("FAIL lat1_data got=%h exp=12345678", if_rdata1);
                end
            end
            if (k == 17) begin
                checks++;
                if (if_rdata15 !== 32'h12345678) begin
                    failures++;
                    $display("FAIL lat15_data got=%h exp=12345678", if_rdata15);
                end
            end
            next_cycle;
        end
    endtask

    initial begin
        rst         = 1'b1;
        if_req      = 1'b0;
        dm_req      = 1'b0;
        dm_we       = 1'b0;
        if_addr     = 32'h0;
        dm_addr     = 32'h0;
        dm_wdata    = 32'h0;
        if_req1     = 1'b0;
        if_req15    = 1'b0;
        const_rdata = 32'h12345678;

        test_reset;
        test_if_read;
        test_contention;
        test_round_robin;
        test_dm_write;
        test_reset_mid;
        test_latency;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter MEM_LAT, default 2: cycles from the memory issue cycle to valid mem_rdata_i; legal range 1..15.
REQ-002 SHALL have port clk_i  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-004 SHALL have ports if_req_i  input  1, and if_addr_i  input  32: instruction-fetch read request and its byte address.
REQ-005 SHALL have ports if_ack_o  output  1, and if_rdata_o  output  32: one-cycle fetch completion pulse and the instruction word read.
REQ-006 SHALL have ports dm_req_i  input  1, dm_we_i  input  1, dm_addr_i  input  32, and dm_wdata_i  input  32: data-memory request, write enable, address and store data.
REQ-007 SHALL have ports dm_ack_o  output  1, and dm_rdata_o  output  32: one-cycle data completion pulse and the load data read.
REQ-008 SHALL have ports mem_en_o  output  1, mem_we_o  output  1, mem_addr_o  output  32, and mem_wdata_o  output  32: command to the shared single-port memory.
REQ-009 SHALL have port mem_rdata_i  input  32: memory read data.
REQ-010 SHALL have ports stall_if_o  output  1, and stall_dm_o  output  1: pipeline freeze requests to the hazard logic.

Function
REQ-011 SHALL implement a state machine with states IDLE, ISSUE, WAIT and DONE, with all outputs except stall_if_o and stall_dm_o registered.
REQ-012 SHALL, in IDLE with any request sampled, latch the winner's address, we and wdata into the mem_* registers, record the winner, and go to ISSUE.
REQ-013 SHALL, in IDLE with no request, remain in IDLE.
REQ-014 SHALL hold mem_en_o=1 for exactly the one ISSUE cycle, and mem_en_o=0 in all other states.
REQ-015 SHALL hold mem_addr_o, mem_we_o and mem_wdata_o stable from ISSUE through DONE.
REQ-016 SHALL set mem_we_o=1 only when the winner is DM with dm_we_i=1; IF requests are always reads.
REQ-017 SHALL, in ISSUE, load the latency counter with MEM_LAT-1, then enter WAIT.
REQ-018 SHALL, in WAIT, decrement the counter each cycle.
REQ-019 SHALL, at the edge where the counter is 0 in WAIT, capture mem_rdata_i into the winner's rdata register and go to DONE.
REQ-020 SHALL treat a MEM_LAT=1 access as spending one WAIT cycle with the counter already 0 on entry.
REQ-021 SHALL, in DONE, pulse the winner's ack for exactly one cycle, then return to IDLE unconditionally.
REQ-022 SHALL give a fixed latency from the request-sampled IDLE cycle N to the ack pulse of N+2+MEM_LAT.
REQ-023 SHALL, on a DM write, leave dm_rdata_o unchanged and still pulse dm_ack_o at the same latency as a read.
REQ-024 SHALL hold if_rdata_o and dm_rdata_o at their last captured value until the next capture for the same requester.
REQ-025 SHALL, when only one request is present in IDLE, grant it.
REQ-026 SHALL, when both requests are present in IDLE, grant the requester not recorded in the 1-bit last_grant register.
REQ-027 SHALL reset last_grant to IF, so DM wins the first contention.
REQ-028 SHALL update last_grant on every grant.
REQ-029 SHALL make stall_if_o = if_req_i AND NOT if_ack_o (combinational).
REQ-030 SHALL make stall_dm_o = dm_req_i AND NOT dm_ack_o (combinational).
REQ-031 SHALL, when a requester deasserts req before its ack (protocol violation), complete the access and still pulse ack.
REQ-032 SHALL ignore request inputs in ISSUE, WAIT and DONE; they are sampled only in IDLE.
REQ-033 SHALL treat a request still high in the IDLE cycle after its ack as a new request.
REQ-034 SHALL never assert if_ack_o and dm_ack_o in the same cycle.

Reset
REQ-035 SHALL, at a clock edge with rst_i=1, force state to IDLE, counter to 0, last_grant to IF, and all registered outputs to 0 (including mem_* and both rdata registers).
REQ-036 SHALL, when reset is asserted mid-access (ISSUE, WAIT or DONE), abandon the access with no ack ever produced for it and mem_en_o=0 from the next cycle.

Verification
REQ-037 SHALL cover: MEM_LAT=2, IF-only read of 0x10 at cycle N with memory returning 0x8C010004 -> mem_en_o=1 only in cycle N+1 with mem_addr_o=0x10 and mem_we_o=0; if_ack_o=1 only in cycle N+4 with if_rdata_o=0x8C010004.
REQ-038 SHALL cover: IF and DM reads both raised at cycle N after reset -> dm_ack_o at N+4, if_ack_o at N+9, and stall_if_o=1 for cycles N..N+8.
REQ-039 SHALL cover: both requests held continuously for 6 grants -> grant order DM, IF, DM, IF, DM, IF.
REQ-040 SHALL cover: DM write of 0xDEADBEEF to 0x20 -> mem_we_o=1, mem_addr_o=0x20 and mem_wdata_o=0xDEADBEEF through ISSUE..DONE; dm_ack_o pulses; dm_rdata_o unchanged.
REQ-041 SHALL cover: rst_i=1 for one cycle during WAIT -> next cycle state IDLE with all outputs 0; no ack for that access; the subsequent request completes normally.
REQ-042 SHALL cover: MEM_LAT=1 and MEM_LAT=15 with an IF read -> ack at N+3 and N+17 respectively.
